instr_prefetch_queue: RTL and testbench

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue_if.sv | 34 +++
 rtl/instr_prefetch_queue.sv | 165 ++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_queue_if.sv
// Bus bundle for instr_prefetch_queue.
// Groups the redirect input, the instruction-memory request/response
// channel, the dequeue channel towards the fetch stage and the occupancy
// count.
//   master : the prefetch queue (drives requests, head entry, occupancy)
//   slave  : its environment (memory, consumer, execute-stage redirect)
interface instr_prefetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic [3:0]  occupancy;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, deq_ready,
        output imem_req_valid, imem_req_addr, deq_valid, deq_pc, deq_instr,
               occupancy
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, deq_ready,
        input  imem_req_valid, imem_req_addr, deq_valid, deq_pc, deq_instr,
               occupancy
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue.
// Issues sequential word-aligned fetch requests, buffers the in-order
// responses together with their PC, and presents the oldest entry to the
// fetch stage. Requests are credit-limited so that buffered entries plus
// in-flight requests never exceed DEPTH; a redirect flushes the queue,
// restarts fetch at the new PC and discards responses still in flight.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : instr_prefetch_queue_if.master
//          redirect/redirect_pc          - flush and restart fetch
//          imem_req_valid/ready/addr     - fetch request channel
//          imem_rsp_valid/data           - in-order response words
//          deq_valid/ready/pc/instr      - head entry to the fetch stage
//          occupancy                     - number of buffered entries
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    rst,
    instr_prefetch_queue_if.master bus
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [3:0]      occ_q, occ_d;
    logic [3:0]      out_q, out_d;
    logic [3:0]      discard_q, discard_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            req_en_q, req_en_d;

    logic [31:0]     mem_pc_q    [DEPTH];
    logic [31:0]     mem_pc_d    [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];
    logic [31:0]     mem_instr_d [DEPTH];

    logic            req_fire;
    logic            deq_fire;
    logic            rsp_in;
    logic            enq;

    // req_en_q is the registered credit/state decision; the redirect gate is
    // the only combinational term so an unaccepted request is withdrawn in
    // the redirect cycle itself.
    assign bus.imem_req_valid = req_en_q & ~bus.redirect;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.deq_valid      = (occ_q != 4'd0);
    assign bus.deq_pc         = mem_pc_q[rd_ptr_q];
    assign bus.deq_instr      = mem_instr_q[rd_ptr_q];
    assign bus.occupancy      = occ_q;

    assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
    assign deq_fire = bus.deq_valid & bus.deq_ready;
    assign rsp_in   = bus.imem_rsp_valid;
    assign enq      = rsp_in & (state_q == RUN) & ~bus.redirect;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        occ_d       = occ_q;
        out_d       = out_q;
        discard_d   = discard_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;

        if (bus.redirect) begin
            // Everything still in flight becomes stale; a response landing
            // in this very cycle is already accounted for and dropped.
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            rsp_pc_d   = bus.redirect_pc & 32'hFFFF_FFFC;
            occ_d      = 4'd0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            out_d      = out_q - 4'(rsp_in);
            discard_d  = out_q - 4'(rsp_in);
            state_d    = (discard_d != 4'd0) ? DRAIN : RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (req_fire) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    out_d = out_q + 4'(req_fire) - 4'(rsp_in);
                end
                DRAIN: begin
                    if (rsp_in) begin
                        discard_d = discard_q - 4'd1;
                        out_d     = out_q - 4'd1;
                        if (discard_d == 4'd0) begin
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Responses arrive in request order, so the PC of the next
            // response is simply a counter that follows the request stream.
            if (enq) begin
                mem_pc_d[wr_ptr_q]    = rsp_pc_q;
                mem_instr_d[wr_ptr_q] = bus.imem_rsp_data;
                wr_ptr_d              = wr_ptr_q + AW'(1);
                rsp_pc_d              = rsp_pc_q + 32'd4;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            occ_d = occ_q + 4'(enq) - 4'(deq_fire);
        end

        req_en_d = (state_d == RUN) &&
                   (({1'b0, occ_d} + {1'b0, out_d}) < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            occ_q      <= 4'd0;
            out_q      <= 4'd0;
            discard_q  <= 4'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            req_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            req_en_q   <= req_en_d;
        end
    end

    // Entry storage carries data only; validity is tracked by occ_q.
    always_ff @(posedge clk) begin
        mem_pc_q    <= mem_pc_d;
        mem_instr_q <= mem_instr_d;
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst;

    instr_prefetch_queue_if bus();

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    pend_t       pend_q[$];     // accepted requests awaiting a response
    ent_t        exp_q[$];      // scoreboard: entries the consumer must see
    int          tests = 0;
    int          fails = 0;
    int          deq_count = 0;
    int unsigned epoch = 0;
    logic [31:0] exp_req_pc;
    bit          popped;
    logic        prev_valid, prev_ready;
    logic [31:0] prev_addr;
    int unsigned p_ready, p_rsp, p_deq, p_redir;
    ent_t        mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every dequeue against the scoreboard head.
    always @(negedge clk) begin
        popped = 1'b0;
        if (rst) begin
            check("occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
            check("deq_valid", 32'(bus.deq_valid), 32'(exp_q.size() != 0));
            if (bus.deq_valid && bus.deq_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL deq_unexpected: got pc %h, want no entry",
                             bus.deq_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("deq_pc", bus.deq_pc, mon_e.pc);
                    check("deq_instr", bus.deq_instr, mon_e.instr);
                    deq_count++;
                    popped = 1'b1;
                end
            end
        end
    end

    // Reference model update for the handshakes of the current cycle.
    task automatic evaluate();
        int    stale;
        pend_t p;
        if (bus.redirect)
            check("valid_in_redirect", 32'(bus.imem_req_valid), 32'd0);
        if (prev_valid && !prev_ready && !bus.redirect) begin
            check("stall_valid", 32'(bus.imem_req_valid), 32'd1);
            check("stall_addr", bus.imem_req_addr, prev_addr);
        end
        if (bus.imem_req_valid) begin
            stale = 0;
            foreach (pend_q[i]) if (pend_q[i].epoch != epoch) stale++;
            check("credit",
                  32'((exp_q.size() + int'(popped) + pend_q.size()) < DEPTH),
                  32'd1);
            check("req_while_stale", 32'(stale), 32'd0);
        end
        prev_valid = bus.imem_req_valid;
        prev_ready = bus.imem_req_ready;
        prev_addr  = bus.imem_req_addr;

        if (bus.imem_rsp_valid) begin
            p = pend_q.pop_front();
            if (!bus.redirect && p.epoch == epoch)
                exp_q.push_back('{p.addr, mem_word(p.addr)});
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_req_pc);
            pend_q.push_back('{exp_req_pc, epoch});
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (bus.redirect) begin
            exp_q.delete();
            epoch++;
            exp_req_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end
    endtask

    task automatic idle_inputs();
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.deq_ready      = 1'b0;
    endtask

    task automatic one_cycle();
        @(posedge clk);
        #1;
        bus.redirect       = ($urandom_range(99) < p_redir);
        bus.redirect_pc    = ($urandom_range(3) == 0) ?
                             (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
        bus.imem_req_ready = ($urandom_range(99) < p_ready);
        bus.deq_ready      = ($urandom_range(99) < p_deq);
        bus.imem_rsp_valid = (pend_q.size() != 0) && ($urandom_range(99) < p_rsp);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(pend_q[0].addr)
                                                : $urandom;
        @(negedge clk);
        #1;
        evaluate();
    endtask

    // Assert reset mid-cycle; outstanding requests are abandoned.
    task automatic apply_reset(input int cycles);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        pend_q.delete();
        exp_q.delete();
        epoch++;
        exp_req_pc = RESET_PC;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        #1;
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        check("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_addr  = 32'd0;
        exp_req_pc = RESET_PC;
        apply_reset(3);

        // Fill with the consumer stalled: requests stop at DEPTH credits.
        p_ready = 100; p_rsp = 100; p_deq = 0; p_redir = 0;
        repeat (12) one_cycle();
        check("fill_occupancy", 32'(bus.occupancy), 32'(DEPTH));
        check("fill_req_stop", 32'(bus.imem_req_valid), 32'd0);
        check("fill_head_pc", bus.deq_pc, RESET_PC);

        // One dequeue frees exactly one credit, which refills the queue.
        p_deq = 100;
        one_cycle();
        p_deq = 0;
        repeat (6) one_cycle();
        check("refill_occupancy", 32'(bus.occupancy), 32'(DEPTH));
        check("refill_head_pc", bus.deq_pc, RESET_PC + 32'd4);

        for (int blk = 0; blk < 15; blk++) begin
            p_ready = $urandom_range(100, 30);
            p_rsp   = $urandom_range(100, 20);
            p_deq   = $urandom_range(100, 10);
            p_redir = $urandom_range(8, 0);
            repeat (200) one_cycle();
            if (blk == 7) apply_reset(2);
        end

        p_redir = 0; p_ready = 100; p_rsp = 100; p_deq = 100;
        repeat (40) one_cycle();
        check("progress", 32'(deq_count > 150), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
